// File: rtl/feed_seq_pkg.sv
// Shared types and width helpers for the feed-register bank sequencer.
package feed_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } feed_seq_state_t;

    localparam int FEED_SEQ_DEPTH_DEF = 8;
    localparam int FEED_SEQ_LEN_W_DEF = 16;

    // Drain counter must be able to hold DEPTH itself.
    function automatic int drain_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int FEED_SEQ_DRAIN_W_DEF = drain_cnt_w(FEED_SEQ_DEPTH_DEF);

endpackage

// File: rtl/feed_seq_cnt.sv
// Loadable down-counter with enable and zero/one flags.
// Load has priority over enable; counting stops at zero so the value never wraps.
module feed_seq_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero,
    output logic         o_one
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load, decrement or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);
    assign o_one  = (cnt_q == W'(1));

endmodule

// File: rtl/feed_sequencer.sv
// Sequencer for one bank of systolic-array feed skew chains.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for i_start; all outputs low
//   ST_CLEAR | one-cycle synchronous clear of the chains (also abort landing)
//   ST_FEED  | accepting upstream beats into the chains
//   ST_DRAIN | shifting zeros in until every chain has flushed
//   ST_DONE  | one-cycle completion pulse
//
// Outputs are a combinational decode of the registered state and the inputs,
// so an async reset drives them all low immediately.
module feed_sequencer
    import feed_seq_pkg::*;
#(
    parameter int DEPTH = FEED_SEQ_DEPTH_DEF,
    parameter int LEN_W = FEED_SEQ_LEN_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_abort,
    input  logic             i_din_valid,
    input  logic             i_stall,
    output logic             o_din_ready,
    output logic             o_pipeline_en,
    output logic             o_clear,
    output logic             o_zero_in,
    output logic             o_busy,
    output logic             o_done
);

    localparam int                 DRAIN_W    = drain_cnt_w(DEPTH);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DEPTH);

    feed_seq_state_t state_q;
    feed_seq_state_t state_d;
    logic            abort_q;
    logic            abort_d;

    logic beat_load;
    logic beat_en;
    logic beat_zero;
    logic beat_one;
    logic drain_load;
    logic drain_en;
    logic drain_zero;
    logic drain_one;
    logic beat_accept;

    feed_seq_cnt #(.W(LEN_W)) u_beat_cnt (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     (beat_load),
        .i_load_val (i_len),
        .i_en       (beat_en),
        .o_zero     (beat_zero),
        .o_one      (beat_one)
    );

    feed_seq_cnt #(.W(DRAIN_W)) u_drain_cnt (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     (drain_load),
        .i_load_val (DRAIN_LOAD),
        .i_en       (drain_en),
        .o_zero     (drain_zero),
        .o_one      (drain_one)
    );

    // Next-state, counter control and output decode.
    always_comb begin
        state_d       = state_q;
        abort_d       = abort_q;
        beat_load     = 1'b0;
        beat_en       = 1'b0;
        drain_load    = 1'b0;
        drain_en      = 1'b0;
        beat_accept   = 1'b0;
        o_din_ready   = 1'b0;
        o_pipeline_en = 1'b0;
        o_clear       = 1'b0;
        o_zero_in     = 1'b0;
        o_done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (i_start) begin
                    beat_load = 1'b1;
                    state_d   = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                // Clear is issued even under stall; it is not a shift.
                o_clear = 1'b1;
                if (i_abort) begin
                    abort_d = 1'b1;
                end else if (abort_q) begin
                    abort_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (beat_zero) begin
                    drain_load = 1'b1;
                    state_d    = ST_DRAIN;
                end else begin
                    state_d = ST_FEED;
                end
            end

            ST_FEED: begin
                if (i_abort) begin
                    // Nothing is consumed or shifted in the abort cycle.
                    abort_d = 1'b1;
                    state_d = ST_CLEAR;
                end else begin
                    o_din_ready   = ~i_stall;
                    o_pipeline_en = i_din_valid & ~i_stall;
                    beat_accept   = i_din_valid & ~i_stall;
                    beat_en       = beat_accept;
                    if (beat_accept && beat_one) begin
                        drain_load = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                o_zero_in = 1'b1;
                if (i_abort) begin
                    abort_d = 1'b1;
                    state_d = ST_CLEAR;
                end else begin
                    o_pipeline_en = ~i_stall;
                    drain_en      = ~i_stall;
                    // drain_zero only guards against a degenerate DEPTH.
                    if (!i_stall && (drain_one || drain_zero)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_busy = (state_q != ST_IDLE);

    // State and abort-flag registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_feed_sequencer.sv
// Bench for feed_sequencer: phase-level reference model checked every cycle,
// a feed-chain model driven by the DUT controls, and directed pass timings.
module tb_feed_sequencer;

    localparam int DEPTH = 8;
    localparam int LEN_W = 16;

    localparam int P_IDLE  = 0;
    localparam int P_CLR   = 1;
    localparam int P_FEED  = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic             i_clk = 1'b0;
    logic             i_rstn = 1'b0;
    logic             i_start = 1'b0;
    logic [LEN_W-1:0] i_len = '0;
    logic             i_abort = 1'b0;
    logic             i_din_valid = 1'b0;
    logic             i_stall = 1'b0;
    logic             o_din_ready;
    logic             o_pipeline_en;
    logic             o_clear;
    logic             o_zero_in;
    logic             o_busy;
    logic             o_done;

    feed_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_start       (i_start),
        .i_len         (i_len),
        .i_abort       (i_abort),
        .i_din_valid   (i_din_valid),
        .i_stall       (i_stall),
        .o_din_ready   (o_din_ready),
        .o_pipeline_en (o_pipeline_en),
        .o_clear       (o_clear),
        .o_zero_in     (o_zero_in),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge i_clk) cyc++;

    // reference model state
    int m_phase = P_IDLE;
    int m_beats = 0;
    int m_drain = 0;
    bit m_aborted = 1'b0;

    // per-pass tallies
    int hs_cnt, pe_cnt, zero_pe_cnt, rdy_cnt, clear_cnt, done_cnt;
    int done_cyc, first_zero_cyc, shift_cnt;
    int chain [DEPTH];
    int outs [32];

    function automatic logic [5:0] model_out(int ph, bit st, bit va, bit ab);
        logic busy, clr, pe, rdy, zi, dn;
        busy = (ph != P_IDLE);
        clr  = (ph == P_CLR);
        dn   = (ph == P_DONE);
        zi   = (ph == P_DRAIN);
        rdy  = (ph == P_FEED) && !ab && !st;
        pe   = ((ph == P_FEED) && va && !ab && !st) || ((ph == P_DRAIN) && !ab && !st);
        return {busy, clr, pe, rdy, zi, dn};
    endfunction

    task automatic clear_tally();
        hs_cnt = 0; pe_cnt = 0; zero_pe_cnt = 0; rdy_cnt = 0; clear_cnt = 0;
        done_cnt = 0; done_cyc = -1; first_zero_cyc = -1; shift_cnt = 0;
        for (int i = 0; i < 32; i++) outs[i] = -1;
    endtask

    // Every-cycle compare, chain model and reference-model step.
    always @(negedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            m_phase   = P_IDLE;
            m_beats   = 0;
            m_drain   = 0;
            m_aborted = 1'b0;
        end else if (!i_clk) begin
            logic [5:0] exp_v, act_v;
            int din;
            exp_v = model_out(m_phase, i_stall, i_din_valid, i_abort);
            act_v = {o_busy, o_clear, o_pipeline_en, o_din_ready, o_zero_in, o_done};
            n_assert++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_cmp cyc=%0d {busy,clear,pe,rdy,zero,done} got=%b want=%b",
                         cyc, act_v, exp_v);
            end

            din = hs_cnt + 1;
            if (o_din_ready && i_din_valid) hs_cnt++;
            if (o_din_ready) rdy_cnt++;
            if (o_clear) begin
                clear_cnt++;
                for (int i = 0; i < DEPTH; i++) chain[i] = 0;
            end else if (o_pipeline_en) begin
                for (int i = DEPTH - 1; i > 0; i--) chain[i] = chain[i-1];
                chain[0] = o_zero_in ? 0 : din;
                shift_cnt++;
                if (shift_cnt < 32) outs[shift_cnt] = chain[DEPTH-1];
            end
            if (o_pipeline_en) pe_cnt++;
            if (o_pipeline_en && o_zero_in) zero_pe_cnt++;
            if (o_zero_in && first_zero_cyc < 0) first_zero_cyc = cyc;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end

            case (m_phase)
                P_IDLE: begin
                    m_aborted = 1'b0;
                    if (i_start) begin
                        m_beats = int'(i_len);
                        m_phase = P_CLR;
                    end
                end
                P_CLR: begin
                    if (i_abort) m_aborted = 1'b1;
                    else if (m_aborted) m_phase = P_IDLE;
                    else if (m_beats == 0) begin
                        m_drain = DEPTH;
                        m_phase = P_DRAIN;
                    end else m_phase = P_FEED;
                end
                P_FEED: begin
                    if (i_abort) begin
                        m_aborted = 1'b1;
                        m_phase   = P_CLR;
                    end else if (i_din_valid && !i_stall) begin
                        m_beats--;
                        if (m_beats == 0) begin
                            m_drain = DEPTH;
                            m_phase = P_DRAIN;
                        end
                    end
                end
                P_DRAIN: begin
                    if (i_abort) begin
                        m_aborted = 1'b1;
                        m_phase   = P_CLR;
                    end else if (!i_stall) begin
                        m_drain--;
                        if (m_drain == 0) m_phase = P_DONE;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp_v);
        n_assert++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
        end
    endtask

    // Per-cycle stimulus for pass cycle k (k=1 is the cycle after i_start).
    task automatic drive(input int mode, input int k);
        i_abort     = 1'b0;
        i_stall     = 1'b0;
        i_din_valid = 1'b1;
        case (mode)
            1: i_stall = ((k >= 3) && (k <= 5)) || (k == 13) || (k == 14);
            2: i_din_valid = (k == 2) || (k == 5) || (k == 7);
            3: i_abort = (k == 4);
            4: i_abort = (k == 6);
            5: begin
                i_start = (k == 3);
                if (k == 3) i_len = LEN_W'(100);
                if (k == 8) begin
                    #2;
                    i_rstn = 1'b0;
                    #1;
                    check("reset_mid_drain_outputs",
                          int'({o_busy, o_clear, o_pipeline_en, o_din_ready, o_zero_in, o_done}), 0);
                end
            end
            default: ;
        endcase
    endtask

    task automatic do_pass(input int len, input int mode, input int budget,
                           output int s, output int end_k);
        bit finished;
        clear_tally();
        i_len   = LEN_W'(len);
        i_start = 1'b1;
        s       = cyc;
        tick();
        i_start  = 1'b0;
        finished = 1'b0;
        end_k    = -1;
        for (int k = 1; k < budget; k++) begin
            if (k > 1 && !o_busy) begin
                finished = 1'b1;
                end_k    = k;
                break;
            end
            drive(mode, k);
            tick();
        end
        if (!finished) check("pass_timeout", 0, 1);
        i_abort = 1'b0; i_stall = 1'b0; i_din_valid = 1'b0; i_start = 1'b0;
    endtask

    initial begin
        int s, ek, nz;
        tick();
        tick();
        check("reset_outputs_low",
              int'({o_busy, o_clear, o_pipeline_en, o_din_ready, o_zero_in, o_done}), 0);
        i_rstn = 1'b1;
        tick();
        check("idle_outputs_low",
              int'({o_busy, o_clear, o_pipeline_en, o_din_ready, o_zero_in, o_done}), 0);

        // nominal: len=4, valid held high
        do_pass(4, 0, 100, s, ek);
        check("nom_done_delay", done_cyc - s, 14);
        check("nom_handshakes", hs_cnt, 4);
        check("nom_drain_shifts", zero_pe_cnt, 8);
        check("nom_clear_cycles", clear_cnt, 1);
        check("nom_chain_out0", outs[8], 1);
        check("nom_chain_out1", outs[9], 2);
        check("nom_chain_out2", outs[10], 3);
        check("nom_chain_out3", outs[11], 4);
        check("nom_chain_tail", outs[12], 0);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (chain[i] != 0) nz++;
        check("nom_chain_flushed", nz, 0);

        // stalls in FEED (3 cycles) and DRAIN (2 cycles)
        do_pass(4, 1, 100, s, ek);
        check("stall_done_delay", done_cyc - s, 19);
        check("stall_handshakes", hs_cnt, 4);
        check("stall_shifts", pe_cnt, 12);

        // bubbly upstream
        do_pass(3, 2, 100, s, ek);
        check("bubble_feed_shifts", pe_cnt - zero_pe_cnt, 3);
        check("bubble_drain_entry", first_zero_cyc - s, 8);
        check("bubble_done_delay", done_cyc - s, 16);

        // len = 0
        do_pass(0, 0, 100, s, ek);
        check("len0_done_delay", done_cyc - s, 10);
        check("len0_ready_cycles", rdy_cnt, 0);
        check("len0_drain_shifts", zero_pe_cnt, 8);

        // abort mid-FEED after 2 of 5 beats
        do_pass(5, 3, 100, s, ek);
        check("abtf_handshakes", hs_cnt, 2);
        check("abtf_done_count", done_cnt, 0);
        check("abtf_clear_count", clear_cnt, 2);
        check("abtf_idle_cycle", ek, 6);
        do_pass(1, 0, 100, s, ek);
        check("after_abort_done_delay", done_cyc - s, 11);
        check("after_abort_handshakes", hs_cnt, 1);

        // abort mid-DRAIN
        do_pass(2, 4, 100, s, ek);
        check("abtd_done_count", done_cnt, 0);
        check("abtd_clear_count", clear_cnt, 2);
        check("abtd_idle_cycle", ek, 8);

        // start ignored while busy, then async reset mid-DRAIN
        do_pass(3, 5, 100, s, ek);
        check("rst_drain_entry", first_zero_cyc - s, 5);
        check("rst_done_count", done_cnt, 0);
        check("rst_back_idle", int'(o_busy), 0);
        i_rstn = 1'b1;
        tick();

        // maximum length completes without wrap
        do_pass(65535, 0, 70000, s, ek);
        check("maxlen_handshakes", hs_cnt, 65535);
        check("maxlen_done_delay", done_cyc - s, 65545);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
